// File: rtl/serial_sub_nbits_pkg.sv
// serial_sub_nbits_pkg: state encoding and geometry check shared by the serial subtractor
package serial_sub_nbits_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic bit digit_ok(int w, int d);
    return d >= 1 && d <= w && (w % d) == 0;
  endfunction
endpackage

// File: rtl/serial_sub_nbits_digit_sub.sv
// serial_sub_nbits_digit_sub: combinational DIGIT-bit ripple-borrow subtractor cell
module serial_sub_nbits_digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bi_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             bo_o
);
  logic [DIGIT:0] br;
  assign br[0] = bi_i;
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign diff_o[i] = a_i[i] ^ b_i[i] ^ br[i];
    assign br[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
  end
  assign bo_o = br[DIGIT];
endmodule

// File: rtl/serial_sub_nbits.sv
// serial_sub_nbits: digit-serial x - y - bin, LSB digit first, with borrow-out and signed overflow
module serial_sub_nbits
  import serial_sub_nbits_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;
  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_geometry
    $error("serial_sub_nbits: WIDTH must be a multiple of DIGIT");
  end
  state_e                 state_q;
  logic [WIDTH-1:0]       x_q, y_q, r_q, d_q;
  logic                   b_q, xs_q, ys_q, done_q, bout_q, ovf_q;
  logic [CW-1:0]          cnt_q;
  logic [DIGIT-1:0]       dig;
  logic                   dig_bo;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       r_d;
  serial_sub_nbits_digit_sub #(.DIGIT(DIGIT)) u_digit (
    .a_i(x_q[DIGIT-1:0]),
    .b_i(y_q[DIGIT-1:0]),
    .bi_i(b_q),
    .diff_o(dig),
    .bo_o(dig_bo)
  );
  // new digit enters at the top; after NDIG steps the LSB digit has reached bit 0
  assign cat = {dig, r_q};
  assign r_d = cat[WIDTH+DIGIT-1:DIGIT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      b_q     <= 1'b0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          x_q     <= x;
          y_q     <= y;
          b_q     <= bin;
          xs_q    <= x[WIDTH-1];
          ys_q    <= y[WIDTH-1];
          cnt_q   <= '0;
          state_q <= RUN;
        end
      end else begin
        x_q   <= x_q >> DIGIT;
        y_q   <= y_q >> DIGIT;
        b_q   <= dig_bo;
        r_q   <= r_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          d_q     <= r_d;
          bout_q  <= dig_bo;
          ovf_q   <= (xs_q != ys_q) && (r_d[WIDTH-1] != xs_q);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      end
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub_nbits.sv
// tb_serial_sub_nbits: random and directed checks of the serial subtractor against an arithmetic model
module tb_serial_sub_nbits;
  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] x, y;
  logic        busy, done, bout, ovf;
  logic [15:0] d;
  int          tests = 0, fails = 0, sweep_done = 0;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_sub_nbits #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {ovf, bout, d} from plain integer arithmetic
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] full;
    int s;
    full = {1'b0, a} - {1'b0, b} - {16'd0, c};
    s = int'($signed(a)) - int'($signed(b)) - int'(c);
    return {(s < -32768 || s > 32767), full};
  endfunction

  int          m_left;
  logic        m_done;
  logic [17:0] m_res, m_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end else if (start) begin
        m_pend = ref16(x, y, bin);
        m_left = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      if (!busy) begin
        check("d", d, m_res[15:0]);
        check("bout", bout, m_res[16]);
        check("ovf", ovf, m_res[17]);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] ed, input logic eb, input logic eo);
    int n;
    start = 1'b1; x = a; y = b; bin = c;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 5);
    check("lit_d", d, ed);
    check("lit_bout", bout, eb);
    check("lit_ovf", ovf, eo);
  endtask

  initial begin
    int last, pulses, n;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    check("model_pin_a", ref16(16'h8000, 16'h0001, 1'b0), {1'b1, 1'b0, 16'h7FFF});
    check("model_pin_b", ref16(16'h0000, 16'h0000, 1'b1), {1'b0, 1'b1, 16'hFFFF});
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_flags", {bout, ovf}, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    run_op(16'h0007, 16'h0006, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0006, 1'b0, 16'hFFFD, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b1; x = 16'h1234; y = 16'h0234; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; x = 16'hFFFF; y = 16'h0000;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ignored_start_d", d, 16'h1000);
    @(negedge clk);
    start = 1'b1; x = 16'h00F0; y = 16'h0F00; bin = 1'b1;
    last = -1; pulses = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) check("hold_period", c - last, 5);
        last = c;
        pulses++;
      end
    end
    check("hold_pulses", pulses >= 3, 1);
    start = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("drain", busy, 0);
    start = 1'b1; x = 16'h5555; y = 16'h1111; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_d", d, 0);
    check("async_rst_flags", {bout, ovf}, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no_done_after_rst", pulses, 0);
    run_op(16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom % 3) == 0;
      x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    n = 0;
    while (sweep_done < 3 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("sweep_finish", sweep_done, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int W = (k == 2) ? 8 : 16;
    localparam int D = (k == 0) ? 1 : (k == 1) ? 16 : 2;
    localparam int N = W / D;
    logic [W-1:0] sx, sy, sd;
    logic         ss, sb, srst, sbusy, sdone, sbo, sov;
    serial_sub_nbits #(.WIDTH(W), .DIGIT(D)) u_sw (
      .clk(clk), .rst(srst), .start(ss), .x(sx), .y(sy), .bin(sb),
      .busy(sbusy), .done(sdone), .d(sd), .bout(sbo), .ovf(sov)
    );
    initial begin
      logic [W:0] full;
      int         s, n;
      srst = 1'b1; ss = 1'b0; sx = '0; sy = '0; sb = 1'b0;
      repeat (2) @(negedge clk);
      srst = 1'b0;
      for (int t = 0; t < 1000; t++) begin
        sx = W'($urandom); sy = W'($urandom); sb = 1'($urandom);
        if (t == 0) begin sx = {1'b1, {(W-1){1'b0}}}; sy = W'(1); sb = 1'b0; end
        if (t == 1) begin sx = '0; sy = '0; sb = 1'b1; end
        if (t == 2) begin sx = {1'b0, {(W-1){1'b1}}}; sy = '1; sb = 1'b0; end
        ss = 1'b1;
        full = {1'b0, sx} - {1'b0, sy} - {{W{1'b0}}, sb};
        s = int'($signed(sx)) - int'($signed(sy)) - int'(sb);
        @(negedge clk);
        ss = 1'b0;
        sx = W'($urandom); sy = W'($urandom);
        n = 1;
        while (!sdone && n < N + 20) begin
          @(negedge clk);
          n++;
        end
        check("sw_latency", n, N + 1);
        check("sw_d", sd, full[W-1:0]);
        check("sw_bout", sbo, full[W]);
        check("sw_ovf", sov, (s < -(2 ** (W - 1)) || s > 2 ** (W - 1) - 1));
      end
      sweep_done++;
    end
  end
endmodule
